// File: rtl/axis_differentiator_pkg.sv
// ----------------------------------------------------------------------------
// axis_differentiator_pkg
// Purpose : shared constants and types for the streaming differentiator.
// Contents: default sample width / parallelism and a signed sample type of
//           the default width.
// ----------------------------------------------------------------------------
package axis_differentiator_pkg;

    localparam int DEFAULT_SAMPLE_WIDTH     = 16;
    localparam int DEFAULT_PARALLEL_SAMPLES = 2;

    typedef logic signed [DEFAULT_SAMPLE_WIDTH-1:0] sample_t;

endpackage : axis_differentiator_pkg

// File: rtl/axis_differentiator_if.sv
// ----------------------------------------------------------------------------
// Axis_If
// Purpose : minimal AXI-Stream style channel (data, valid, ready) with a
//           derived transfer strobe ok = valid && ready.
// Modports: master drives data/valid and observes ready/ok;
//           slave drives ready and observes data/valid/ok.
// ----------------------------------------------------------------------------
interface Axis_If #(
    parameter int DWIDTH = 32
);
    logic [DWIDTH-1:0] data;
    logic              valid;
    logic              ready;
    logic              ok;

    assign ok = valid && ready;

    modport master (
        output data,
        output valid,
        input  ready,
        input  ok
    );

    modport slave (
        input  data,
        input  valid,
        output ready,
        input  ok
    );
endinterface : Axis_If

// File: rtl/axis_differentiator.sv
// ----------------------------------------------------------------------------
// axis_differentiator
// Purpose : first-difference filter on a multi-sample-per-beat stream,
//           y[k] = floor((x[k] - x[k-1]) / 2), one register stage.
// Ports   : clk      - clock, rising edge
//           reset    - synchronous reset, active low
//           data_in  - Axis_If slave, PARALLEL_SAMPLES samples per beat
//                      (sample 0 in the low bits, oldest in time)
//           data_out - Axis_If master, same packing as data_in
// ----------------------------------------------------------------------------
module axis_differentiator
    import axis_differentiator_pkg::*;
#(
    parameter int SAMPLE_WIDTH     = DEFAULT_SAMPLE_WIDTH,
    parameter int PARALLEL_SAMPLES = DEFAULT_PARALLEL_SAMPLES
) (
    input  logic   clk,
    input  logic   reset,
    Axis_If.slave  data_in,
    Axis_If.master data_out
);

    localparam int DW = SAMPLE_WIDTH * PARALLEL_SAMPLES;

    logic [DW-1:0]                  w_result;
    logic                           w_accept;
    logic signed [SAMPLE_WIDTH-1:0] r_prev;
    logic [DW-1:0]                  r_data;
    logic                           r_valid;

    // The output stage can take a new beat whenever it is empty or being
    // drained this cycle, so upstream sees a pure combinational pass-through.
    assign data_in.ready = data_out.ready || !r_valid;

    // Nothing enters state while reset is held, even if ok is high.
    assign w_accept = data_in.ok && reset;

    assign data_out.data  = r_data;
    assign data_out.valid = r_valid;

    // Per-sample difference. Sample 0 pairs with the last sample of the
    // previous accepted beat; the others pair with their lower neighbour.
    // The subtraction is one bit wider so it cannot wrap, and the arithmetic
    // shift floors the halving, which brings the result back into range.
    for (genvar gi = 0; gi < PARALLEL_SAMPLES; gi++) begin : g_diff
        logic signed [SAMPLE_WIDTH-1:0] w_cur;
        logic signed [SAMPLE_WIDTH-1:0] w_old;
        logic signed [SAMPLE_WIDTH:0]   w_diff;

        assign w_cur = data_in.data[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];

        if (gi == 0) begin : g_first
            assign w_old = r_prev;
        end else begin : g_rest
            assign w_old = data_in.data[(gi-1)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end

        assign w_diff = {w_cur[SAMPLE_WIDTH-1], w_cur}
                      - {w_old[SAMPLE_WIDTH-1], w_old};

        assign w_result[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
            SAMPLE_WIDTH'(w_diff >>> 1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_prev  <= '0;
        end else begin
            if (w_accept) begin
                // Load covers both the empty case and the drain-and-refill
                // case, so back-to-back transfers never insert a bubble.
                r_valid <= 1'b1;
                r_data  <= w_result;
                r_prev  <= data_in.data[DW-1 -: SAMPLE_WIDTH];
            end else if (data_out.ok) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule : axis_differentiator

// File: tb/tb_axis_differentiator.sv
module tb_axis_differentiator;
    import axis_differentiator_pkg::*;

    localparam int SW = 16;
    localparam int PS = 2;
    localparam int DW = SW * PS;

    typedef struct {
        logic [DW-1:0] din;
        logic [DW-1:0] dexp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    Axis_If #(.DWIDTH(DW)) in_if ();
    Axis_If #(.DWIDTH(DW)) out_if ();

    axis_differentiator #(
        .SAMPLE_WIDTH     (SW),
        .PARALLEL_SAMPLES (PS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (in_if.slave),
        .data_out (out_if.master)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            n_acc = 0;
    int            n_out = 0;
    logic [DW-1:0] sb_q[$];
    sample_t       model_prev = '0;
    logic          use_tab = 1'b0;
    logic [DW-1:0] tab_exp = '0;
    logic          hold_chk = 1'b0;
    logic [DW-1:0] hold_data = '0;

    vec_t tab[7];

    // Reference: exact floor of the halved difference, done in int arithmetic.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input sample_t p);
        logic [DW-1:0] r;
        int x, o, diff, y;
        for (int i = 0; i < PS; i++) begin
            x = int'($signed(d[i*SW +: SW]));
            o = (i == 0) ? int'(p) : int'($signed(d[(i-1)*SW +: SW]));
            diff = x - o;
            y = diff / 2;
            if (diff < 0 && (diff % 2) != 0) y = y - 1;
            r[i*SW +: SW] = y[SW-1:0];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One clock: observe combinational handshakes at the falling edge,
    // update the scoreboard, then return just after the rising edge.
    task automatic tick();
        logic [DW-1:0] e;
        @(negedge clk);
        check("ready_passthru", DW'(in_if.ready), DW'(out_if.ready || !out_if.valid));
        if (!reset) begin
            sb_q.delete();
            model_prev = '0;
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                check("hold_valid", DW'(out_if.valid), DW'(1));
                check("hold_data", out_if.data, hold_data);
            end
            if (out_if.valid === 1'b1 && out_if.ready === 1'b1) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got %h, expected no beat", out_if.data);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", out_if.data, e);
                    $display("out beat %h (exp %h)", out_if.data, e);
                end
            end
            if (in_if.valid === 1'b1 && in_if.ready === 1'b1) begin
                e = use_tab ? tab_exp : model(in_if.data, model_prev);
                sb_q.push_back(e);
                model_prev = sample_t'(in_if.data[DW-1 -: SW]);
                n_acc++;
            end
            hold_chk = out_if.valid && !out_if.ready;
            hold_data = out_if.data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k = 0;
        in_if.valid = 1'b0;
        out_if.ready = 1'b1;
        while ((sb_q.size() != 0 || out_if.valid === 1'b1) && k < 50) begin
            tick();
            k++;
        end
        check(name, DW'(sb_q.size()), DW'(0));
    endtask

    initial begin
        int acc0, out0;

        tab[0] = '{{16'h00C8, 16'h0064}, {16'd50,   16'd50}};
        tab[1] = '{{16'h0000, 16'hFF9C}, {16'd50,   16'hFF6A}};
        tab[2] = '{{16'h8000, 16'h0000}, {16'hC000, 16'h0000}};
        tab[3] = '{{16'h8000, 16'h7FFF}, {16'h8000, 16'h7FFF}};
        tab[4] = '{{16'hFFFF, 16'h0001}, {16'hFFFF, 16'h4000}};
        tab[5] = '{{16'h0000, 16'hFFFD}, {16'h0001, 16'hFFFF}};
        tab[6] = '{{16'h0000, 16'hFFFF}, {16'h0000, 16'hFFFF}};

        // Reset state
        reset = 1'b0;
        in_if.valid = 1'b0;
        in_if.data = '0;
        out_if.ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", DW'(out_if.valid), DW'(0));
        check("rst_data", out_if.data, '0);
        check("rst_in_ready", DW'(in_if.ready), DW'(1));
        reset = 1'b1;
        tick();

        // Table vectors, back to back with the sink always ready
        use_tab = 1'b1;
        out_if.ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_if.valid = 1'b1;
            in_if.data = tab[i].din;
            tab_exp = tab[i].dexp;
            $display("in  beat %h (vector %0d)", tab[i].din, i);
            tick();
            check("latency_valid", DW'(out_if.valid), DW'(1));
        end
        drain("table_drain");
        use_tab = 1'b0;

        // Sink stalled for 5 cycles with input valid: one beat accepted
        acc0 = n_acc;
        out_if.ready = 1'b0;
        in_if.valid = 1'b1;
        in_if.data = {16'h0010, 16'h0020};
        tick();
        for (int i = 0; i < 4; i++) begin
            check("stall_in_ready", DW'(in_if.ready), DW'(0));
            tick();
        end
        check("stall_accepted", DW'(n_acc - acc0), DW'(1));
        out_if.ready = 1'b1;
        in_if.data = {16'h0030, 16'h0005};
        tick();
        check("no_bubble_valid", DW'(out_if.valid), DW'(1));
        check("stall_accepted2", DW'(n_acc - acc0), DW'(2));
        drain("stall_drain");

        // Mid-stream reset with an output pending
        out_if.ready = 1'b0;
        in_if.valid = 1'b1;
        in_if.data = {16'h1234, 16'h0111};
        tick();
        reset = 1'b0;
        in_if.data = {16'h7777, 16'h3333};
        tick();
        check("midrst_valid", DW'(out_if.valid), DW'(0));
        reset = 1'b1;
        use_tab = 1'b1;
        out_if.ready = 1'b1;
        in_if.valid = 1'b1;
        in_if.data = {16'd6, 16'd4};
        tab_exp = {16'd1, 16'd2};
        tick();
        check("postrst_valid", DW'(out_if.valid), DW'(1));
        drain("postrst_drain");
        use_tab = 1'b0;

        // Random valid/ready/data
        acc0 = n_acc;
        out0 = n_out;
        for (int c = 0; c < 2000; c++) begin
            in_if.valid = 1'($urandom_range(0, 1));
            in_if.data = DW'($urandom);
            out_if.ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain("random_drain");
        check("random_count", DW'(n_out - out0), DW'(n_acc - acc0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_axis_differentiator

// File: doc/axis_differentiator.md
AXIS_DIFFERENTIATOR -- requirements
Module: axis_differentiator

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16: width of one signed two's-complement sample.
REQ-002 SHALL have parameter PARALLEL_SAMPLES, default 2: samples per beat; sample i occupies bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]; sample 0 is the oldest in time.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port data_in, Axis_If slave, DWIDTH = SAMPLE_WIDTH*PARALLEL_SAMPLES: data, valid, ready (ready is an output); ok = valid && ready.
REQ-006 SHALL have port data_out, Axis_If master, DWIDTH = SAMPLE_WIDTH*PARALLEL_SAMPLES: data and valid are outputs; ready is an input.

Function
REQ-007 Input samples SHALL form one continuous stream x[k], k = beat*PARALLEL_SAMPLES + i.
REQ-008 Output sample y[k] SHALL equal floor((x[k] - x[k-1]) / 2).
REQ-009 y[k] SHALL be computed at SAMPLE_WIDTH+1 bits, then the LSB dropped (arithmetic shift right by 1), so it never overflows SAMPLE_WIDTH.
REQ-010 For sample 0 of a beat, x[k-1] SHALL be the last sample (index PARALLEL_SAMPLES-1) of the previously accepted beat.
REQ-011 x[-1] SHALL be 0, so the first beat after reset gives y[0] = floor(x[0]/2).
REQ-012 The stored previous sample SHALL update only on data_in.ok; beats not transferred SHALL not affect state.
REQ-013 The block SHALL use one register stage: a beat accepted on cycle t SHALL appear on data_out with valid high from cycle t+1.
REQ-014 data_in.ready SHALL equal data_out.ready || !data_out.valid, as a combinational pass-through.
REQ-015 While data_out.valid is high and data_out.ready is low, data_out.data and data_out.valid SHALL hold stable.
REQ-016 On a cycle with data_out.ok and no data_in.ok, data_out.valid SHALL drop to 0.
REQ-017 When data_out.ok and data_in.ok occur in the same cycle, the new result SHALL load with no bubble.
REQ-018 Every accepted input beat SHALL produce exactly one output beat, in order, with nothing dropped or duplicated under arbitrary valid/ready patterns.

Reset
REQ-019 While reset = 0, data_out.valid, data_out.data and the stored previous sample SHALL clear to 0.
REQ-020 While reset = 0, data_in.ready SHALL follow REQ-014, and no beat SHALL be accepted into state.
REQ-021 A reset asserted mid-stream SHALL discard any pending output beat.
REQ-022 After a mid-stream reset, the next beat SHALL be treated as the first (REQ-011).

Structure
REQ-023 The shared package SHALL hold the default SAMPLE_WIDTH and PARALLEL_SAMPLES constants and a signed sample typedef.
REQ-024 The Axis_If interface SHALL be the existing codebase interface (data, valid, ready, ok).
REQ-025 The arithmetic SHALL be a generate loop over PARALLEL_SAMPLES inside the module.
REQ-026 The output register and handshake logic MAY be a sub-module axis_register_slice; no other sub-module is required.

Verification
REQ-027 Reset, then one beat x = {0x0064, 0x00C8} (sample0 = 100, sample1 = 200) -> y = {50, 50}.
REQ-028 Next beat x = {0xFF9C, 0x0000} (sample0 = -100, sample1 = 0) -> y = {floor(-300/2) = -150, 50}.
REQ-029 Extremes: previous sample 0x8000, then a beat {0x7FFF, 0x8000} -> y = {0x7FFF, 0x8000}, i.e. 32767 and -32768, with no wrap.
REQ-030 2000 cycles of random valid and ready, random data -> output count equals input count and every sample matches a reference model within ±1 LSB.
REQ-031 data_out.ready held at 0 for 5 cycles with valid input -> exactly one beat is accepted, output holds stable, and data_in.ready is 0 until data_out.ready rises.
REQ-032 Reset pulled to 0 mid-stream with output pending -> data_out.valid is 0 the next cycle, and the first post-reset beat {4, 6} gives {2, 1}.
